axi4lite_axi4_conv: RTL and testbench

AXI4LITE_AXI4_CONV -- requirements
Module: axi4lite_axi4_conv

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi4lite_axi4_conv.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_axi4lite_axi4_conv.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Purpose     : shared constants and FSM state types for the AXI4-Lite to AXI4 bridge.
// Latency     : n/a (definitions only).
// Backpressure: n/a (definitions only).
package axi_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] LEN_SINGLE  = 8'd0;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ISSUE  = 2'd1,
        W_WAIT_B = 2'd2,
        W_RESP   = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ISSUE  = 2'd1,
        R_WAIT_R = 2'd2,
        R_RESP   = 2'd3
    } r_state_t;

endpackage

// File: rtl/axi4lite_axi4_conv.sv
// Purpose     : AXI4-Lite slave to AXI4 master bridge; one write and one read in flight, single-beat bursts.
// Latency     : 1 cycle inport request -> outport valid; 1 cycle outport response -> inport valid.
// Backpressure: inport readies drop once a request is held; every valid stays stable until its handshake.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   inport_aw*/w*/b*/ar*/r*  : AXI4-Lite slave side
//   outport_aw*/w*/b*/ar*/r* : AXI4 master side (ID = AXI_ID, len 0, INCR, wlast 1)
// Option macro AXI4LITE_AXI4_CONV_ID_CHECK_EN: responses with a foreign ID (or rlast low on
// reads) are reported as SLVERR; without it the response code passes through untouched.
module axi4lite_axi4_conv
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        inport_awvalid_i,
    input  logic [31:0] inport_awaddr_i,
    output logic        inport_awready_o,
    input  logic        inport_wvalid_i,
    input  logic [31:0] inport_wdata_i,
    input  logic [3:0]  inport_wstrb_i,
    output logic        inport_wready_o,
    output logic        inport_bvalid_o,
    output logic [1:0]  inport_bresp_o,
    input  logic        inport_bready_i,
    input  logic        inport_arvalid_i,
    input  logic [31:0] inport_araddr_i,
    output logic        inport_arready_o,
    output logic        inport_rvalid_o,
    output logic [31:0] inport_rdata_o,
    output logic [1:0]  inport_rresp_o,
    input  logic        inport_rready_i,

    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    input  logic        outport_awready_i,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        outport_rready_o
);

    // ------------------------------------------------------------------
    // Response code qualification
    // ------------------------------------------------------------------
    logic [1:0] bresp_chk;
    logic [1:0] rresp_chk;

`ifdef AXI4LITE_AXI4_CONV_ID_CHECK_EN
    assign bresp_chk = (outport_bid_i != AXI_ID) ? RESP_SLVERR : outport_bresp_i;
    assign rresp_chk = ((outport_rid_i != AXI_ID) || !outport_rlast_i) ? RESP_SLVERR : outport_rresp_i;
`else
    // Tags are meaningless with a single outstanding transaction per direction.
    logic unused_resp_tags;
    assign unused_resp_tags = ^{outport_bid_i, outport_rid_i, outport_rlast_i};
    assign bresp_chk        = outport_bresp_i;
    assign rresp_chk        = outport_rresp_i;
`endif

    // ------------------------------------------------------------------
    // Fixed single-beat burst attributes
    // ------------------------------------------------------------------
    assign outport_awid_o    = AXI_ID;
    assign outport_awlen_o   = LEN_SINGLE;
    assign outport_awburst_o = BURST_INCR;
    assign outport_wlast_o   = 1'b1;
    assign outport_arid_o    = AXI_ID;
    assign outport_arlen_o   = LEN_SINGLE;
    assign outport_arburst_o = BURST_INCR;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t    w_state_q, w_state_d;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_held_q, w_held_q;   // inport AW / W captured in W_IDLE
    logic        aw_done_q, w_done_q;   // outport AW / W handshake completed in W_ISSUE
    logic [1:0]  bresp_q;

    assign outport_awaddr_o = aw_addr_q;
    assign outport_wdata_o  = w_data_q;
    assign outport_wstrb_o  = w_strb_q;
    assign inport_bresp_o   = bresp_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d         = w_state_q;
        inport_awready_o  = 1'b0;
        inport_wready_o   = 1'b0;
        outport_awvalid_o = 1'b0;
        outport_wvalid_o  = 1'b0;
        outport_bready_o  = 1'b0;
        inport_bvalid_o   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                inport_awready_o = !aw_held_q;
                inport_wready_o  = !w_held_q;
                // Either half may arrive this cycle or already be held.
                if ((aw_held_q || inport_awvalid_i) && (w_held_q || inport_wvalid_i)) begin
                    w_state_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                outport_awvalid_o = !aw_done_q;
                outport_wvalid_o  = !w_done_q;
                if ((aw_done_q || outport_awready_i) && (w_done_q || outport_wready_i)) begin
                    w_state_d = W_WAIT_B;
                end
            end
            W_WAIT_B: begin
                outport_bready_o = 1'b1;
                if (outport_bvalid_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                inport_bvalid_o = 1'b1;
                if (inport_bready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (inport_awvalid_i && !aw_held_q) begin
                        aw_addr_q <= inport_awaddr_i;
                        aw_held_q <= 1'b1;
                    end
                    if (inport_wvalid_i && !w_held_q) begin
                        w_data_q <= inport_wdata_i;
                        w_strb_q <= inport_wstrb_i;
                        w_held_q <= 1'b1;
                    end
                end
                W_ISSUE: begin
                    if (outport_awvalid_o && outport_awready_i) begin
                        aw_done_q <= 1'b1;
                    end
                    if (outport_wvalid_o && outport_wready_i) begin
                        w_done_q <= 1'b1;
                    end
                    // Leaving ISSUE frees the holding slots for the next request.
                    if (w_state_d == W_WAIT_B) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end
                end
                W_WAIT_B: begin
                    if (outport_bvalid_i) begin
                        bresp_q <= bresp_chk;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t    r_state_q, r_state_d;
    logic [31:0] ar_addr_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    assign outport_araddr_o = ar_addr_q;
    assign inport_rdata_o   = rdata_q;
    assign inport_rresp_o   = rresp_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d         = r_state_q;
        inport_arready_o  = 1'b0;
        outport_arvalid_o = 1'b0;
        outport_rready_o  = 1'b0;
        inport_rvalid_o   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                inport_arready_o = 1'b1;
                if (inport_arvalid_i) begin
                    r_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                outport_arvalid_o = 1'b1;
                if (outport_arready_i) begin
                    r_state_d = R_WAIT_R;
                end
            end
            R_WAIT_R: begin
                outport_rready_o = 1'b1;
                if (outport_rvalid_i) begin
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                inport_rvalid_o = 1'b1;
                if (inport_rready_i) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ar_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (inport_arvalid_i) begin
                        ar_addr_q <= inport_araddr_i;
                    end
                end
                R_WAIT_R: begin
                    if (outport_rvalid_i) begin
                        rdata_q <= outport_rdata_i;
                        rresp_q <= rresp_chk;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_axi4_conv.sv
module tb_axi4lite_axi4_conv;

    localparam logic [3:0] TB_ID = 4'd0;

    logic        clk, rst_i;
    logic        inport_awvalid_i, inport_awready_o;
    logic [31:0] inport_awaddr_i;
    logic        inport_wvalid_i, inport_wready_o;
    logic [31:0] inport_wdata_i;
    logic [3:0]  inport_wstrb_i;
    logic        inport_bvalid_o, inport_bready_i;
    logic [1:0]  inport_bresp_o;
    logic        inport_arvalid_i, inport_arready_o;
    logic [31:0] inport_araddr_i;
    logic        inport_rvalid_o, inport_rready_i;
    logic [31:0] inport_rdata_o;
    logic [1:0]  inport_rresp_o;
    logic        outport_awvalid_o, outport_awready_i;
    logic [31:0] outport_awaddr_o;
    logic [3:0]  outport_awid_o;
    logic [7:0]  outport_awlen_o;
    logic [1:0]  outport_awburst_o;
    logic        outport_wvalid_o, outport_wlast_o, outport_wready_i;
    logic [31:0] outport_wdata_o;
    logic [3:0]  outport_wstrb_o;
    logic        outport_bvalid_i, outport_bready_o;
    logic [1:0]  outport_bresp_i;
    logic [3:0]  outport_bid_i;
    logic        outport_arvalid_o, outport_arready_i;
    logic [31:0] outport_araddr_o;
    logic [3:0]  outport_arid_o;
    logic [7:0]  outport_arlen_o;
    logic [1:0]  outport_arburst_o;
    logic        outport_rvalid_i, outport_rlast_i, outport_rready_o;
    logic [31:0] outport_rdata_i;
    logic [1:0]  outport_rresp_i;
    logic [3:0]  outport_rid_i;

    axi4lite_axi4_conv #(.AXI_ID(TB_ID)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .inport_awvalid_i(inport_awvalid_i), .inport_awaddr_i(inport_awaddr_i), .inport_awready_o(inport_awready_o),
        .inport_wvalid_i(inport_wvalid_i), .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i),
        .inport_wready_o(inport_wready_o),
        .inport_bvalid_o(inport_bvalid_o), .inport_bresp_o(inport_bresp_o), .inport_bready_i(inport_bready_i),
        .inport_arvalid_i(inport_arvalid_i), .inport_araddr_i(inport_araddr_i), .inport_arready_o(inport_arready_o),
        .inport_rvalid_o(inport_rvalid_o), .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
        .inport_rready_i(inport_rready_i),
        .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o), .outport_awid_o(outport_awid_o),
        .outport_awlen_o(outport_awlen_o), .outport_awburst_o(outport_awburst_o), .outport_awready_i(outport_awready_i),
        .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o),
        .outport_wlast_o(outport_wlast_o), .outport_wready_i(outport_wready_i),
        .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i), .outport_bid_i(outport_bid_i),
        .outport_bready_o(outport_bready_o),
        .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o), .outport_arid_o(outport_arid_o),
        .outport_arlen_o(outport_arlen_o), .outport_arburst_o(outport_arburst_o), .outport_arready_i(outport_arready_i),
        .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
        .outport_rid_i(outport_rid_i), .outport_rlast_i(outport_rlast_i), .outport_rready_o(outport_rready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: pushed when stimulus is driven, popped at DUT handshakes.
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];   // {strb, data}
    logic [1:0]  exp_b[$];
    logic [31:0] exp_ar[$];
    logic [33:0] exp_r[$];   // {resp, data}
    int aw_seen = 0;
    int w_seen  = 0;

    // Slave-model controls.
    logic [1:0]  slv_bresp = 2'b00;
    logic [3:0]  slv_bid   = TB_ID;
    logic [31:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [3:0]  slv_rid   = TB_ID;
    logic        slv_b_hold = 1'b0;
    int          aw_stall  = 0;
    int          slv_aw_cnt = 0;
    int          slv_w_cnt  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- AXI4 slave model on the outport ----------------
    initial begin : slave
        bit aw_f, w_f, b_f, ar_f, r_f, awv;
        outport_awready_i = 1'b1; outport_wready_i = 1'b1; outport_arready_i = 1'b1;
        outport_bvalid_i = 1'b0; outport_bresp_i = 2'b00; outport_bid_i = TB_ID;
        outport_rvalid_i = 1'b0; outport_rdata_i = '0; outport_rresp_i = 2'b00;
        outport_rid_i = TB_ID; outport_rlast_i = 1'b1;
        forever begin
            @(negedge clk);
            aw_f = outport_awvalid_o && outport_awready_i;
            w_f  = outport_wvalid_o && outport_wready_i;
            b_f  = outport_bvalid_i && outport_bready_o;
            ar_f = outport_arvalid_o && outport_arready_i;
            r_f  = outport_rvalid_i && outport_rready_o;
            awv  = outport_awvalid_o;
            cyc();
            if (rst_i !== 1'b1) begin
                slv_aw_cnt = 0; slv_w_cnt = 0;
                outport_bvalid_i = 1'b0; outport_rvalid_i = 1'b0; outport_awready_i = 1'b1;
            end else begin
                if (aw_f) slv_aw_cnt++;
                if (w_f) slv_w_cnt++;
                if (b_f) outport_bvalid_i = 1'b0;
                if (r_f) outport_rvalid_i = 1'b0;
                if (slv_aw_cnt > 0 && slv_w_cnt > 0 && !outport_bvalid_i && !slv_b_hold) begin
                    slv_aw_cnt--; slv_w_cnt--;
                    outport_bvalid_i = 1'b1; outport_bresp_i = slv_bresp; outport_bid_i = slv_bid;
                end
                if (ar_f) begin
                    outport_rvalid_i = 1'b1; outport_rdata_i = slv_rdata;
                    outport_rresp_i = slv_rresp; outport_rid_i = slv_rid; outport_rlast_i = 1'b1;
                end
                if (awv && !aw_f && aw_stall > 0) aw_stall--;
                outport_awready_i = (aw_stall == 0);
            end
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    initial begin : monitor
        logic [31:0] e32;
        logic [35:0] e36;
        logic [33:0] e34;
        logic [1:0]  e2;
        logic        aw_pend;
        logic [31:0] aw_pend_addr;
        aw_pend = 1'b0;
        aw_pend_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_i !== 1'b1) begin
                aw_pend = 1'b0;
            end else begin
                if (aw_pend) begin
                    checks++;
                    if (outport_awvalid_o !== 1'b1 || outport_awaddr_o !== aw_pend_addr) begin
                        errors++;
                        $display("FAIL aw_stable: valid %b addr %h, required 1 addr %h",
                                 outport_awvalid_o, outport_awaddr_o, aw_pend_addr);
                    end
                end
                aw_pend = outport_awvalid_o && !outport_awready_i;
                aw_pend_addr = outport_awaddr_o;
                if (outport_awvalid_o && outport_awready_i) begin
                    aw_seen++; checks++;
                    if (exp_aw.size() == 0) begin
                        errors++; $display("FAIL aw_unexpected: addr %h, required no AW", outport_awaddr_o);
                    end else begin
                        e32 = exp_aw.pop_front();
                        if ({outport_awaddr_o, outport_awlen_o, outport_awburst_o, outport_awid_o} !==
                            {e32, 8'd0, 2'b01, TB_ID}) begin
                            errors++;
                            $display("FAIL aw_fields: addr %h len %h burst %b id %h, required addr %h len 00 burst 01 id %h",
                                     outport_awaddr_o, outport_awlen_o, outport_awburst_o, outport_awid_o, e32, TB_ID);
                        end
                    end
                end
                if (outport_wvalid_o && outport_wready_i) begin
                    w_seen++; checks++;
                    if (exp_w.size() == 0) begin
                        errors++; $display("FAIL w_unexpected: data %h, required no W", outport_wdata_o);
                    end else begin
                        e36 = exp_w.pop_front();
                        if ({outport_wstrb_o, outport_wdata_o, outport_wlast_o} !== {e36, 1'b1}) begin
                            errors++;
                            $display("FAIL w_fields: strb %h data %h last %b, required strb %h data %h last 1",
                                     outport_wstrb_o, outport_wdata_o, outport_wlast_o, e36[35:32], e36[31:0]);
                        end
                    end
                end
                if (outport_arvalid_o && outport_arready_i) begin
                    checks++;
                    if (exp_ar.size() == 0) begin
                        errors++; $display("FAIL ar_unexpected: addr %h, required no AR", outport_araddr_o);
                    end else begin
                        e32 = exp_ar.pop_front();
                        if ({outport_araddr_o, outport_arlen_o, outport_arburst_o, outport_arid_o} !==
                            {e32, 8'd0, 2'b01, TB_ID}) begin
                            errors++;
                            $display("FAIL ar_fields: addr %h len %h burst %b id %h, required addr %h len 00 burst 01",
                                     outport_araddr_o, outport_arlen_o, outport_arburst_o, outport_arid_o, e32);
                        end
                    end
                end
                if (inport_bvalid_o && inport_bready_i) begin
                    checks++;
                    if (exp_b.size() == 0) begin
                        errors++; $display("FAIL b_unexpected: bresp %b, required no B", inport_bresp_o);
                    end else begin
                        e2 = exp_b.pop_front();
                        if (inport_bresp_o !== e2) begin
                            errors++; $display("FAIL bresp: got %b, required %b", inport_bresp_o, e2);
                        end
                    end
                end
                if (inport_rvalid_o && inport_rready_i) begin
                    checks++;
                    if (exp_r.size() == 0) begin
                        errors++; $display("FAIL r_unexpected: data %h, required no R", inport_rdata_o);
                    end else begin
                        e34 = exp_r.pop_front();
                        if ({inport_rresp_o, inport_rdata_o} !== e34) begin
                            errors++;
                            $display("FAIL rdata_rresp: data %h resp %b, required data %h resp %b",
                                     inport_rdata_o, inport_rresp_o, e34[31:0], e34[33:32]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- Inport master tasks ----------------
    task automatic send_aw(input logic [31:0] addr, input int delay);
        int n;
        logic hs;
        repeat (delay) cyc();
        inport_awvalid_i = 1'b1; inport_awaddr_i = addr;
        n = 0;
        do begin
            @(negedge clk); hs = inport_awready_o; cyc(); n++;
        end while (!hs && n < 100);
        inport_awvalid_i = 1'b0;
        if (!hs) begin checks++; errors++; $display("FAIL aw_accept_timeout: awready %b, required 1", hs); end
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
        int n;
        logic hs;
        repeat (delay) cyc();
        inport_wvalid_i = 1'b1; inport_wdata_i = data; inport_wstrb_i = strb;
        n = 0;
        do begin
            @(negedge clk); hs = inport_wready_o; cyc(); n++;
        end while (!hs && n < 100);
        inport_wvalid_i = 1'b0;
        if (!hs) begin checks++; errors++; $display("FAIL w_accept_timeout: wready %b, required 1", hs); end
    endtask

    task automatic send_ar(input logic [31:0] addr);
        int n;
        logic hs;
        inport_arvalid_i = 1'b1; inport_araddr_i = addr;
        n = 0;
        do begin
            @(negedge clk); hs = inport_arready_o; cyc(); n++;
        end while (!hs && n < 100);
        inport_arvalid_i = 1'b0;
        if (!hs) begin checks++; errors++; $display("FAIL ar_accept_timeout: arready %b, required 1", hs); end
    endtask

    task automatic take_b(input int hold);
        int n;
        logic [1:0] r0;
        n = 0;
        @(negedge clk);
        while (inport_bvalid_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (inport_bvalid_o !== 1'b1) begin
            errors++; $display("FAIL b_timeout: bvalid %b, required 1", inport_bvalid_o); return;
        end
        r0 = inport_bresp_o;
        repeat (hold) begin
            @(negedge clk); checks++;
            if (inport_bvalid_o !== 1'b1 || inport_bresp_o !== r0) begin
                errors++; $display("FAIL b_stable: bvalid %b bresp %b, required 1 %b", inport_bvalid_o, inport_bresp_o, r0);
            end
        end
        cyc(); inport_bready_i = 1'b1;
        cyc(); inport_bready_i = 1'b0;
    endtask

    task automatic take_r(input int hold);
        int n;
        logic [33:0] r0;
        n = 0;
        @(negedge clk);
        while (inport_rvalid_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (inport_rvalid_o !== 1'b1) begin
            errors++; $display("FAIL r_timeout: rvalid %b, required 1", inport_rvalid_o); return;
        end
        r0 = {inport_rresp_o, inport_rdata_o};
        repeat (hold) begin
            @(negedge clk); checks++;
            if (inport_rvalid_o !== 1'b1 || {inport_rresp_o, inport_rdata_o} !== r0) begin
                errors++; $display("FAIL r_stable: rvalid %b data %h resp %b, required 1 %h %b",
                                   inport_rvalid_o, inport_rdata_o, inport_rresp_o, r0[31:0], r0[33:32]);
            end
        end
        cyc(); inport_rready_i = 1'b1;
        cyc(); inport_rready_i = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int bhold, input bit want_b);
        exp_aw.push_back(addr);
        exp_w.push_back({strb, data});
        if (want_b) exp_b.push_back(slv_bresp);
        fork
            send_aw(addr, aw_dly);
            send_w(data, strb, w_dly);
        join
        if (want_b) take_b(bhold);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] slave_resp,
                           input logic [1:0] resp_exp, input int hold);
        slv_rdata = data;
        slv_rresp = slave_resp;
        exp_ar.push_back(addr);
        exp_r.push_back({resp_exp, data});
        send_ar(addr);
        take_r(hold);
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({inport_awready_o, inport_wready_o, inport_arready_o} !== 3'b111) begin
            errors++; $display("FAIL reset_readies: %b, required 111", {inport_awready_o, inport_wready_o, inport_arready_o});
        end
        checks++;
        if ({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, inport_bvalid_o, inport_rvalid_o} !== 5'b0) begin
            errors++; $display("FAIL reset_valids: %b, required 00000",
                               {outport_awvalid_o, outport_wvalid_o, outport_arvalid_o, inport_bvalid_o, inport_rvalid_o});
        end
        checks++;
        if ({outport_bready_o, outport_rready_o} !== 2'b00) begin
            errors++; $display("FAIL reset_out_readies: %b, required 00", {outport_bready_o, outport_rready_o});
        end
        checks++;
        if ({inport_bresp_o, inport_rresp_o, inport_rdata_o} !== 36'd0) begin
            errors++; $display("FAIL reset_resp: bresp %b rresp %b rdata %h, required 0", inport_bresp_o, inport_rresp_o, inport_rdata_o);
        end
        checks++;
        if ({outport_awaddr_o, outport_wdata_o, outport_wstrb_o, outport_araddr_o} !== 100'd0) begin
            errors++; $display("FAIL reset_hold_regs: awaddr %h wdata %h wstrb %h araddr %h, required 0",
                               outport_awaddr_o, outport_wdata_o, outport_wstrb_o, outport_araddr_o);
        end
        checks++;
        if ({outport_awlen_o, outport_awburst_o, outport_wlast_o, outport_arlen_o, outport_arburst_o, outport_awid_o, outport_arid_o}
            !== {8'd0, 2'b01, 1'b1, 8'd0, 2'b01, TB_ID, TB_ID}) begin
            errors++; $display("FAIL fixed_attrs: awlen %h awburst %b wlast %b arlen %h arburst %b, required 00 01 1 00 01",
                               outport_awlen_o, outport_awburst_o, outport_wlast_o, outport_arlen_o, outport_arburst_o);
        end
        cyc(); rst_i = 1'b1;
        cyc();
    endtask

    task automatic test_same_cycle();
        int n;
        exp_aw.push_back(32'h1000);
        exp_w.push_back({4'hF, 32'hDEAD_BEEF});
        exp_b.push_back(2'b00);
        inport_awvalid_i = 1'b1; inport_awaddr_i = 32'h1000;
        inport_wvalid_i = 1'b1; inport_wdata_i = 32'hDEAD_BEEF; inport_wstrb_i = 4'hF;
        @(negedge clk); checks++;
        if ({inport_awready_o, inport_wready_o} !== 2'b11) begin
            errors++; $display("FAIL same_cycle_ready: %b, required 11", {inport_awready_o, inport_wready_o});
        end
        cyc(); inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0;
        @(negedge clk); checks++;
        if ({outport_awvalid_o, outport_wvalid_o} !== 2'b11) begin
            errors++; $display("FAIL req_latency: aw/w valid %b one cycle after capture, required 11", {outport_awvalid_o, outport_wvalid_o});
        end
        n = 0;
        while (!(outport_bvalid_i === 1'b1 && outport_bready_o === 1'b1) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin
            errors++; $display("FAIL outport_b_timeout: bready %b bvalid %b, required 1 1", outport_bready_o, outport_bvalid_i);
        end
        @(negedge clk); checks++;
        if (inport_bvalid_o !== 1'b1) begin
            errors++; $display("FAIL resp_latency: inport bvalid %b one cycle after outport B, required 1", inport_bvalid_o);
        end
        cyc();
        take_b(0);
    endtask

    task automatic test_w_before_aw();
        int a0, w0;
        a0 = aw_seen; w0 = w_seen;
        aw_stall = 5;
        exp_aw.push_back(32'h0000_5000);
        exp_w.push_back({4'h5, 32'h0BAD_F00D});
        exp_b.push_back(slv_bresp);
        fork
            begin
                send_w(32'h0BAD_F00D, 4'h5, 0);
                repeat (2) begin
                    @(negedge clk); checks++;
                    if ({inport_wready_o, inport_awready_o} !== 2'b01) begin
                        errors++; $display("FAIL wready_after_capture: wready %b awready %b, required 0 1",
                                           inport_wready_o, inport_awready_o);
                    end
                end
            end
            send_aw(32'h0000_5000, 3);
        join
        take_b(1);
        checks++;
        if (aw_seen - a0 != 1 || w_seen - w0 != 1) begin
            errors++; $display("FAIL single_write: aw %0d w %0d outport beats, required 1 1", aw_seen - a0, w_seen - w0);
        end
    endtask

    task automatic test_read();
        do_read(32'h2004, 32'h1234_5678, 2'b00, 2'b00, 4);
    endtask

    task automatic test_concurrent();
        fork
            do_write(32'h3000, 32'hA5A5_0001, 4'h3, 0, 1, 2, 1'b1);
            do_read(32'h4008, 32'hCAFE_F00D, 2'b00, 2'b00, 1);
        join
    endtask

    task automatic test_id_check();
        logic [1:0] want;
`ifdef AXI4LITE_AXI4_CONV_ID_CHECK_EN
        want = 2'b10;
`else
        want = 2'b00;
`endif
        slv_rid = 4'h3;
        do_read(32'h2008, 32'h0F0F_1234, 2'b00, want, 0);
        slv_rid = TB_ID;
    endtask

    task automatic test_reset_mid_write();
        int n;
        slv_b_hold = 1'b1;
        do_write(32'h6000, 32'h1111_2222, 4'hF, 0, 0, 0, 1'b0);
        n = 0;
        @(negedge clk);
        while (outport_bready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (outport_bready_o !== 1'b1) begin
            errors++; $display("FAIL wait_b_reach: bready %b, required 1", outport_bready_o);
        end
        cyc(); rst_i = 1'b0;
        @(negedge clk); checks++;
        if ({inport_bvalid_o, outport_bready_o, inport_awready_o, inport_wready_o} !== 4'b0011) begin
            errors++; $display("FAIL mid_reset_state: bvalid %b bready %b awready %b wready %b, required 0 0 1 1",
                               inport_bvalid_o, outport_bready_o, inport_awready_o, inport_wready_o);
        end
        cyc(); rst_i = 1'b1; slv_b_hold = 1'b0;
        repeat (6) begin
            @(negedge clk); checks++;
            if (inport_bvalid_o !== 1'b0) begin
                errors++; $display("FAIL abandoned_b: bvalid %b after reset, required 0", inport_bvalid_o);
            end
        end
        cyc();
        do_write(32'h6004, 32'h3333_4444, 4'hC, 0, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            slv_bresp = 2'($urandom_range(0, 3));
            do_write($urandom, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), 1'b1);
            begin
                logic [1:0] rr;
                rr = 2'($urandom_range(0, 3));
                do_read($urandom, $urandom, rr, rr, $urandom_range(0, 2));
            end
        end
        slv_bresp = 2'b00;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin : main
        rst_i = 1'b0;
        inport_awvalid_i = 1'b0; inport_awaddr_i = '0;
        inport_wvalid_i = 1'b0; inport_wdata_i = '0; inport_wstrb_i = '0;
        inport_bready_i = 1'b0;
        inport_arvalid_i = 1'b0; inport_araddr_i = '0;
        inport_rready_i = 1'b0;
        cyc();
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_read();
        test_concurrent();
        test_id_check();
        test_reset_mid_write();
        test_back_to_back();
        repeat (4) cyc();
        checks++;
        if (exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: aw %0d w %0d b %0d ar %0d r %0d left, required 0",
                               exp_aw.size(), exp_w.size(), exp_b.size(), exp_ar.size(), exp_r.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
